// File: rtl/xalu_seq.sv
// xalu_seq: word-wide sequencer driving one 4-bit xalu slice a nibble per cycle.
// Optional signed ADD overflow flag enabled by defining XALU_SEQ_OVF_EN.
module xalu_seq #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [2:0]   func_i,
  input  logic         com_i,
  input  logic         cin_i,
  input  logic [W-1:0] op_a_i,
  input  logic [W-1:0] op_b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] result_o,
  output logic         cout_o,
  output logic         zero_o,
  output logic         equ_o,
  output logic         ovf_o,
  output logic [3:0]   sl_a_o,
  output logic [3:0]   sl_b_o,
  output logic [2:0]   sl_f_o,
  output logic         sl_com_o,
  output logic         sl_ci_right_o,
  output logic         sl_ci_left_o,
  input  logic [3:0]   sl_d_i,
  input  logic         sl_co_left_i,
  input  logic         sl_co_right_i,
  input  logic         sl_zero_i,
  input  logic         sl_equ_i
);
  localparam int IW = $clog2(NIBBLES);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SHR = 3'd6;
  logic [1:0]    st_q, st_d;
  logic [IW-1:0] idx_q, idx_d, nib;
  logic [2:0]    func_q, func_d;
  logic          com_q, com_d, cy_q, cy_d, cout_q, cout_d, zero_q, zero_d, equ_q, equ_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic          run, accept, shr, last;
  assign run    = st_q == RUN;
  assign accept = st_q == IDLE && start_i;
  assign shr    = func_q == F_SHR;
  assign last   = idx_q == IW'(NIBBLES - 1);
  // SHR walks MSB nibble first so the shift-out ripples toward the LSB
  assign nib    = shr ? IW'(NIBBLES - 1) - idx_q : idx_q;
  assign sl_a_o        = run ? a_q[4*nib +: 4] : 4'd0;
  assign sl_b_o        = run ? b_q[4*nib +: 4] : 4'd0;
  assign sl_f_o        = run ? func_q : 3'd0;
  assign sl_com_o      = run & com_q;
  assign sl_ci_right_o = run & ~shr & cy_q;
  assign sl_ci_left_o  = run & shr & cy_q;
  assign busy_o   = st_q != IDLE;
  assign done_o   = st_q == DONE;
  assign result_o = res_q;
  assign cout_o   = cout_q;
  assign zero_o   = zero_q;
  assign equ_o    = equ_q;
  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    func_d = func_q;
    com_d  = com_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    cy_d   = cy_q;
    cout_d = cout_q;
    zero_d = zero_q;
    equ_d  = equ_q;
    if (accept) begin
      st_d   = RUN;
      idx_d  = '0;
      func_d = func_i;
      com_d  = com_i;
      a_d    = op_a_i;
      b_d    = op_b_i;
      res_d  = '0;
      cy_d   = cin_i;
      cout_d = 1'b0;
      zero_d = 1'b1;
      equ_d  = 1'b1;
    end else if (run) begin
      res_d[4*nib +: 4] = sl_d_i;
      cy_d   = shr ? sl_co_right_i : sl_co_left_i;
      zero_d = zero_q & sl_zero_i;
      equ_d  = equ_q & sl_equ_i;
      idx_d  = idx_q + 1'b1;
      if (last) begin
        st_d   = DONE;
        cout_d = shr ? sl_co_right_i : sl_co_left_i;
      end
    end else if (st_q == DONE) begin
      st_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      idx_q  <= '0;
      func_q <= 3'd0;
      com_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cy_q   <= 1'b0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
      equ_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      func_q <= func_d;
      com_q  <= com_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      cy_q   <= cy_d;
      cout_q <= cout_d;
      zero_q <= zero_d;
      equ_q  <= equ_d;
    end
  end
`ifdef XALU_SEQ_OVF_EN
  logic ovf_q;
  assign ovf_o = ovf_q;
  // sl_d[3]^com recovers the true sum MSB when the slice complements its output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else if (accept) ovf_q <= 1'b0;
    else if (run && last) ovf_q <= func_q == F_ADD && a_q[W-1] == b_q[W-1] && (sl_d_i[3] ^ com_q) != a_q[W-1];
  end
`else
  assign ovf_o = 1'b0;
`endif
endmodule

// File: tb/tb_xalu_seq.sv
// tb_xalu_seq: directed and random checks of xalu_seq against a word-level model,
// with a behavioural 4-bit slice closing the loop.
module tb_xalu_seq;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic         clk = 1'b0;
  logic         rst, start, com, cin;
  logic [2:0]   func;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, cout, zero, equ, ovf;
  logic [W-1:0] result;
  logic [3:0]   sl_a, sl_b, sl_d;
  logic [2:0]   sl_f;
  logic         sl_com, sl_ci_right, sl_ci_left, sl_co_left, sl_co_right, sl_zero, sl_equ;
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] seq[$];
  always #5 clk = ~clk;
  xalu_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start_i(start), .func_i(func), .com_i(com), .cin_i(cin),
    .op_a_i(op_a), .op_b_i(op_b), .busy_o(busy), .done_o(done), .result_o(result),
    .cout_o(cout), .zero_o(zero), .equ_o(equ), .ovf_o(ovf),
    .sl_a_o(sl_a), .sl_b_o(sl_b), .sl_f_o(sl_f), .sl_com_o(sl_com),
    .sl_ci_right_o(sl_ci_right), .sl_ci_left_o(sl_ci_left),
    .sl_d_i(sl_d), .sl_co_left_i(sl_co_left), .sl_co_right_i(sl_co_right),
    .sl_zero_i(sl_zero), .sl_equ_i(sl_equ)
  );
  // behavioural slice
  always_comb begin
    logic [4:0] s;
    logic [3:0] raw;
    s = {1'b0, sl_a} + {1'b0, sl_b} + {4'd0, sl_ci_right};
    raw = 4'd0;
    sl_co_left = 1'b0;
    sl_co_right = 1'b0;
    case (sl_f)
      3'd0: begin raw = s[3:0]; sl_co_left = s[4]; end
      3'd1: raw = sl_a & sl_b;
      3'd2: raw = sl_a | sl_b;
      3'd3: raw = sl_a ^ sl_b;
      3'd4: raw = sl_a;
      3'd5: raw = sl_b;
      3'd6: begin raw = {sl_ci_left, sl_a[3:1]}; sl_co_right = sl_a[0]; end
      default: begin raw = {sl_a[2:0], sl_ci_right}; sl_co_left = sl_a[3]; end
    endcase
    sl_d = raw ^ {4{sl_com}};
    sl_zero = sl_d == 4'd0;
    sl_equ = sl_a == sl_b;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [2:0] f, input logic c, ci, input logic [W-1:0] a, b,
                       output logic [W-1:0] r, output logic co, z, eq, ov);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    co = 1'b0;
    ov = 1'b0;
    case (f)
      3'd0: begin r = s[W-1:0]; co = s[W]; ov = a[W-1] == b[W-1] && s[W-1] != a[W-1]; end
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = a;
      3'd5: r = b;
      3'd6: begin r = {ci, a[W-1:1]}; co = a[0]; end
      default: begin r = {a[W-2:0], ci}; co = a[W-1]; end
    endcase
`ifndef XALU_SEQ_OVF_EN
    ov = 1'b0;
`endif
    r = r ^ {W{c}};
    z = r == '0;
    eq = a == b;
  endtask
  task automatic run_op(input logic [2:0] f, input logic c, ci, input logic [W-1:0] a, b, input bit poke);
    logic [W-1:0] r;
    logic co, z, eq, ov;
    int edges, ndone;
    model(f, c, ci, a, b, r, co, z, eq, ov);
    seq.delete();
    @(negedge clk);
    start = 1'b1; func = f; com = c; cin = ci; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    while (!done && edges < 20) begin
      if (busy) seq.push_back(sl_a);
      if (poke && edges == 2) begin start = 1'b1; op_a = ~a; func = ~f; end
      if (poke && edges == 3) start = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", edges, N + 1);
    chk("result", result, r);
    chk("cout", cout, co);
    chk("zero", zero, z);
    chk("equ", equ, eq);
    chk("ovf", ovf, ov);
    chk("nibble_count", seq.size(), N);
    ndone = 0;
    repeat (6) begin
      @(posedge clk); #1;
      ndone += done;
    end
    chk("done_pulses_after", ndone, 0);
    chk("idle_busy", busy, 0);
    chk("idle_slice", {sl_a, sl_b, sl_f, sl_com, sl_ci_right, sl_ci_left}, 0);
    chk("result_held", result, r);
  endtask
  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; func = 3'd0; com = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {result, cout, zero, equ, ovf, busy, done}, 0);
    chk("reset_slice", {sl_a, sl_b, sl_f, sl_com, sl_ci_right, sl_ci_left}, 0);
    @(negedge clk) rst = 1'b0;
    run_op(3'd0, 1'b0, 1'b0, 16'h1234, 16'h0FFF, 1'b0);
    chk("add_result_const", result, 16'h2233);
    run_op(3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    chk("add_wrap_cout", {cout, zero}, 2'b11);
    run_op(3'd0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
`ifdef XALU_SEQ_OVF_EN
    chk("ovf_set", ovf, 1);
`else
    chk("ovf_tied", ovf, 0);
`endif
    run_op(3'd7, 1'b0, 1'b1, 16'h8001, 16'h0000, 1'b0);
    chk("shl_result", {cout, result}, 17'h10003);
    chk("shl_order", {seq[0], seq[1], seq[2], seq[3]}, 16'h1008);
    run_op(3'd6, 1'b0, 1'b0, 16'h8001, 16'h0000, 1'b0);
    chk("shr_result", {cout, result}, 17'h14000);
    chk("shr_order", {seq[0], seq[1], seq[2], seq[3]}, 16'h8001);
    run_op(3'd3, 1'b1, 1'b0, 16'hA5A5, 16'hA5A5, 1'b0);
    chk("xor_com", {result, equ, zero, cout}, {16'hFFFF, 3'b100});
    run_op(3'd0, 1'b0, 1'b1, 16'h4321, 16'h1111, 1'b1);
    chk("poke_result", result, 16'h5433);
    // reset during RUN with idx=2
    @(negedge clk);
    start = 1'b1; func = 3'd0; com = 1'b0; cin = 1'b0; op_a = 16'h1111; op_b = 16'h2222;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_outs", {result, cout, zero, equ, ovf, busy, done}, 0);
    chk("midrst_slice", {sl_a, sl_b, sl_f, sl_com, sl_ci_right, sl_ci_left}, 0);
    @(negedge clk) rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      ndone += done;
    end
    chk("midrst_no_done", ndone, 0);
    run_op(3'd1, 1'b0, 1'b0, 16'hF0F0, 16'h3C3C, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b,
             $urandom_range(0, 4) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
